cache_req_arbiter: RTL and testbench
====================================

Name: cache_req_arbiter

Overview:
- Shares the single read port of cache_system_2level between two requesters: port 0 is instruction fetch, port 1 is data.
- Arbitrates round-robin, issues a one-cycle read pulse to the cache, waits a fixed response latency, then returns data and hit flags to the granting requester.
- Keeps saturating L1-hit / L2-hit / miss statistics counters.
- Sits between the requesters and cache_system_2level. It is the only master of the cache read port.

Parameters:
- ADDR_WIDTH, 11, address width; matches the cache.
- DATA_WIDTH, 11, data width; matches the cache.
- RESP_LAT, 2, cycles from the cache_read cycle to the cache_read cycle's sampled response. Must be >= 1.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- r0_req_valid  in  1  requester 0 has a request.
- r0_req_addr  in  ADDR_WIDTH  requester 0 address.
- r0_req_ready  out  1  requester 0 request accepted this cycle.
- r0_resp_valid  out  1  one-cycle response strobe to requester 0.
- r1_req_valid  in  1  requester 1 has a request.
- r1_req_addr  in  ADDR_WIDTH  requester 1 address.
- r1_req_ready  out  1  requester 1 request accepted this cycle.
- r1_resp_valid  out  1  one-cycle response strobe to requester 1.
- resp_data  out  DATA_WIDTH  response data, shared by both requesters; qualified by rN_resp_valid.
- resp_l1_hit  out  1  L1 hit flag, shared; qualified by rN_resp_valid.
- resp_l2_hit  out  1  L2 hit flag, shared; qualified by rN_resp_valid.
- cache_addr  out  ADDR_WIDTH  address to the cache.
- cache_read  out  1  read pulse to the cache.
- cache_read_data  in  DATA_WIDTH  data from the cache.
- cache_l1_hit  in  1  L1 hit flag from the cache.
- cache_l2_hit  in  1  L2 hit flag from the cache.
- clr_stats  in  1  synchronous clear of the statistics counters.
- l1_hit_cnt  out  CNT_WIDTH  L1 hit count.
- l2_hit_cnt  out  CNT_WIDTH  L2 hit count.
- miss_cnt  out  CNT_WIDTH  miss count.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - All outputs 0, including all counters and cache_addr.
  - Reset mid-transaction abandons the transaction: no resp_valid, and cache_read is 0 from the next cycle.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Only one valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - rN_req_ready = (state==IDLE) & granted; this is combinational from state, last_grant and the valids.
  - On handshake (valid & ready): latch addr and owner, update last_grant, go to ISSUE.
  - No valid: stay in IDLE.
- Requester protocol: hold req_valid and req_addr stable until ready. A request withdrawn before ready is legal and is simply not granted.
- ISSUE (1 cycle):
  - cache_read=1 and cache_addr=latched addr.
  - Load wait counter with RESP_LAT-1, go to WAIT.
  - If RESP_LAT=1, the WAIT phase takes zero cycles and the response is sampled at the end of the first WAIT-position cycle.
- WAIT:
  - cache_read=0; cache_addr holds the latched address for the whole transaction.
  - Decrement the counter. At the end of the cycle in which the counter is 0, sample cache_read_data, cache_l1_hit and cache_l2_hit into the resp registers, then go to RESP.
- RESP (1 cycle):
  - The owner's rN_resp_valid=1; the other requester's resp_valid=0.
  - Go to IDLE. No response backpressure.
- resp_data and the hit flags hold their last values until the next sample.
- Latency: handshake in cycle H -> cache_read in H+1 -> sample at end of H+RESP_LAT -> resp_valid in H+RESP_LAT+1.
  - With RESP_LAT=2: cache_read at H+1, resp_valid at H+3.
- Next handshake: possible no earlier than H+RESP_LAT+2, i.e. one per RESP_LAT+2 cycles.
- Statistics, updated on entry to RESP:
  - l1_hit -> l1_hit_cnt+1.
  - else l2_hit -> l2_hit_cnt+1.
  - else miss_cnt+1.
  - l1 and l2 both high counts as L1 only.
  - Each counter saturates at 2^CNT_WIDTH-1.
  - clr_stats zeroes all three counters next cycle and wins over a simultaneous increment.

Decomposition:
- Package cache_ctrl_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - FSM state encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3.
  - Requester-id constants REQ_IF=0 and REQ_DATA=1.
- Sub-module sat_counter (CNT_WIDTH; inc, clr, cnt; clr priority), instantiated three times.
- Arbitration stays inline.

Test Plan:
- Single request:
  - Stimulus: r0 requests 11'h123 after reset; cache model returns data after RESP_LAT=2 with l1=0, l2=0.
  - Response: cache_read for exactly one cycle with cache_addr=11'h123; r0_resp_valid exactly 3 cycles after handshake; miss_cnt=1.
- Round-robin tie:
  - Stimulus: both valid at reset exit (r0 11'h123, r1 11'h2A3), held valid.
  - Response: grant order r0, r1, r0, r1; each resp_valid goes only to its owner; throughput 1 per 4 cycles.
- Hit classification:
  - Stimulus: responses (l1,l2) = (1,0), (0,1), (1,1), (0,0).
  - Response: l1_hit_cnt=2, l2_hit_cnt=1, miss_cnt=1.
- Saturation and clear:
  - Stimulus: CNT_WIDTH=2, five L1 hits.
  - Response: l1_hit_cnt stays 3.
  - Stimulus: clr_stats asserted in the same cycle as a hit.
  - Response: l1_hit_cnt=0 next cycle.
- Reset mid-operation:
  - Stimulus: rst asserted during WAIT of an r1 request to 11'h345.
  - Response: no r1_resp_valid ever for it; state IDLE; counters 0.
  - Stimulus: new r0 request after reset.
  - Response: r0 is granted first.
- Withdrawn request:
  - Stimulus: r1 raises valid during r0's transaction, then drops it before IDLE.
  - Response: no grant to r1 and no cache_read for it.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache request arbiter.
// Holds FSM encoding, requester ids and default widths.
package cache_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic REQ_IF   = 1'b0;
  localparam logic REQ_DATA = 1'b1;

endpackage

// File: rtl/cache_req_arbiter_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear takes priority over a same-cycle increment.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // next count: clear, else increment unless already at max
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin sharing of the cache read port between ifetch and data.
// Issues one read, waits a fixed latency, returns data and hit flags.
module cache_req_arbiter
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RESP_LAT   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req_valid,
  input  logic [ADDR_WIDTH-1:0] r0_req_addr,
  output logic                  r0_req_ready,
  output logic                  r0_resp_valid,
  input  logic                  r1_req_valid,
  input  logic [ADDR_WIDTH-1:0] r1_req_addr,
  output logic                  r1_req_ready,
  output logic                  r1_resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_l1_hit,
  output logic                  resp_l2_hit,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_read,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  input  logic                  cache_l1_hit,
  input  logic                  cache_l2_hit,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  l1_hit_cnt,
  output logic [CNT_WIDTH-1:0]  l2_hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  localparam int WW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WW-1:0]         wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rl1_q, rl1_d;
  logic                  rl2_q, rl2_d;
  logic                  rd_q, rd_d;
  logic                  rv0_q, rv0_d;
  logic                  rv1_q, rv1_d;
  logic                  gnt0, gnt1, hs0, hs1, smp;

  // round-robin grant; the requester not granted last wins a tie
  always_comb begin
    gnt0 = r0_req_valid & (~r1_req_valid | (last_q == REQ_DATA));
    gnt1 = r1_req_valid & (~r0_req_valid | (last_q == REQ_IF));
    r0_req_ready = (state_q == ST_IDLE) & gnt0;
    r1_req_ready = (state_q == ST_IDLE) & gnt1;
    hs0 = r0_req_valid & r0_req_ready;
    hs1 = r1_req_valid & r1_req_ready;
  end

  // FSM next state; wait counter runs from the read cycle onward
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    rl1_d   = rl1_q;
    rl2_d   = rl2_q;
    rd_d    = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    smp     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hs0 | hs1) begin
          state_d = ST_ISSUE;
          owner_d = hs1 ? REQ_DATA : REQ_IF;
          last_d  = hs1 ? REQ_DATA : REQ_IF;
          addr_d  = hs1 ? r1_req_addr : r0_req_addr;
          wcnt_d  = WW'(RESP_LAT - 1);
          rd_d    = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (wcnt_q == '0) begin
          smp = 1'b1;
        end else begin
          wcnt_d  = wcnt_q - WW'(1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) smp = 1'b1;
        else              wcnt_d = wcnt_q - WW'(1);
      end
      ST_RESP: state_d = ST_IDLE;
    endcase
    if (smp) begin
      state_d = ST_RESP;
      rdata_d = cache_read_data;
      rl1_d   = cache_l1_hit;
      rl2_d   = cache_l2_hit;
      rv0_d   = (owner_q == REQ_IF);
      rv1_d   = (owner_q == REQ_DATA);
    end
  end

  // FSM, transaction and registered-output state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= REQ_DATA;
      owner_q <= REQ_IF;
      addr_q  <= '0;
      wcnt_q  <= '0;
      rdata_q <= '0;
      rl1_q   <= 1'b0;
      rl2_q   <= 1'b0;
      rd_q    <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      rl1_q   <= rl1_d;
      rl2_q   <= rl2_d;
      rd_q    <= rd_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign cache_addr    = addr_q;
  assign cache_read    = rd_q;
  assign resp_data     = rdata_q;
  assign resp_l1_hit   = rl1_q;
  assign resp_l2_hit   = rl2_q;
  assign r0_resp_valid = rv0_q;
  assign r1_resp_valid = rv1_q;

  logic inc_l1, inc_l2, inc_miss;

  // classify each sampled response; L1 wins when both flags are set
  always_comb begin
    inc_l1   = smp & cache_l1_hit;
    inc_l2   = smp & ~cache_l1_hit & cache_l2_hit;
    inc_miss = smp & ~cache_l1_hit & ~cache_l2_hit;
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_l1_cnt (
    .clk(clk), .rst(rst), .inc(inc_l1), .clr(clr_stats), .cnt(l1_hit_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_l2_cnt (
    .clk(clk), .rst(rst), .inc(inc_l2), .clr(clr_stats), .cnt(l2_hit_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .rst(rst), .inc(inc_miss), .clr(clr_stats), .cnt(miss_cnt)
  );

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a combinational cache model.
// Counters run at width 2 so saturation is reachable.
module tb_cache_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_v, r1_v;
  logic [10:0] r0_a, r1_a;
  logic        r0_rdy, r1_rdy, r0_rv, r1_rv;
  logic [10:0] rdata, caddr, cdata;
  logic        rl1, rl2, cread, tb_l1, tb_l2, clr;
  logic [1:0]  l1c, l2c, mc;

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  assign cdata = caddr ^ 11'h5A5;

  cache_req_arbiter #(
    .ADDR_WIDTH(11), .DATA_WIDTH(11), .RESP_LAT(2), .CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .r0_req_valid(r0_v), .r0_req_addr(r0_a),
    .r0_req_ready(r0_rdy), .r0_resp_valid(r0_rv),
    .r1_req_valid(r1_v), .r1_req_addr(r1_a),
    .r1_req_ready(r1_rdy), .r1_resp_valid(r1_rv),
    .resp_data(rdata), .resp_l1_hit(rl1), .resp_l2_hit(rl2),
    .cache_addr(caddr), .cache_read(cread),
    .cache_read_data(cdata),
    .cache_l1_hit(tb_l1), .cache_l2_hit(tb_l2),
    .clr_stats(clr),
    .l1_hit_cnt(l1c), .l2_hit_cnt(l2c), .miss_cnt(mc)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // one full transaction for requester p; clr_stats optionally
  // asserted in the cycle the response is sampled
  task automatic do_txn(input bit p, input logic [10:0] a,
                        input logic l1, input logic l2,
                        input bit c);
    int n;
    n = 0;
    tb_l1 = l1;
    tb_l2 = l2;
    if (p) begin r1_v = 1'b1; r1_a = a; end
    else   begin r0_v = 1'b1; r0_a = a; end
    #1;
    while (!(p ? r1_rdy : r0_rdy) && n < 8) begin
      step();
      n++;
    end
    chk("grant", p ? r1_rdy : r0_rdy, 1);
    chk("other_rdy", p ? r0_rdy : r1_rdy, 0);
    step();
    r0_v = 1'b0;
    r1_v = 1'b0;
    chk("rd_issue", cread, 1);
    chk("rd_addr", caddr, a);
    step();
    clr = c;
    chk("rd_off", cread, 0);
    chk("addr_hold", caddr, a);
    chk("rv_early", r0_rv | r1_rv, 0);
    step();
    clr = 1'b0;
    chk("rv_own", p ? r1_rv : r0_rv, 1);
    chk("rv_other", p ? r0_rv : r1_rv, 0);
    chk("rdata", rdata, a ^ 11'h5A5);
    chk("rl1", rl1, l1);
    chk("rl2", rl2, l2);
    step();
    chk("rv_drop", r0_rv | r1_rv, 0);
  endtask

  initial begin
    r0_v = 0; r1_v = 0; r0_a = 0; r1_a = 0;
    tb_l1 = 0; tb_l2 = 0; clr = 0;
    do_reset();

    chk("rst_rd", cread, 0);
    chk("rst_addr", caddr, 0);
    chk("rst_rv", {r0_rv, r1_rv}, 0);
    chk("rst_cnt", {l1c, l2c, mc}, 0);

    // single request, miss
    do_txn(0, 11'h123, 0, 0, 0);
    chk("single_miss", mc, 1);
    chk("single_l1", l1c, 0);

    // round-robin tie from reset exit, both held valid
    rst = 1'b1;
    r0_v = 1; r0_a = 11'h123;
    r1_v = 1; r1_a = 11'h2A3;
    tb_l1 = 0; tb_l2 = 0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("rr_rdy0", r0_rdy, (k % 8) == 0);
      chk("rr_rdy1", r1_rdy, (k % 8) == 4);
      chk("rr_rv0", r0_rv, (k % 8) == 3);
      chk("rr_rv1", r1_rv, (k % 8) == 7);
      if ((k % 4) == 1)
        chk("rr_addr", caddr, ((k % 8) == 1) ? 11'h123 : 11'h2A3);
      step();
    end
    r0_v = 0;
    r1_v = 0;
    chk("rr_miss_sat", mc, 3);
    step();

    // hit classification
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_cnt", {l1c, l2c, mc}, 0);
    do_txn(0, 11'h010, 1, 0, 0);
    do_txn(1, 11'h020, 0, 1, 0);
    do_txn(0, 11'h030, 1, 1, 0);
    do_txn(1, 11'h040, 0, 0, 0);
    chk("cls_l1", l1c, 2);
    chk("cls_l2", l2c, 1);
    chk("cls_miss", mc, 1);

    // saturation at 3 after five L1 hits
    for (int i = 0; i < 5; i++)
      do_txn(i[0], 11'h100 + 11'(i), 1, 0, 0);
    chk("sat_l1", l1c, 3);
    chk("sat_l2", l2c, 1);

    // clear wins over same-cycle hit
    do_txn(0, 11'h0AA, 1, 0, 1);
    chk("clr_win_l1", l1c, 0);
    chk("clr_win_miss", mc, 0);

    // reset mid-WAIT of an r1 request
    do_txn(0, 11'h0BB, 1, 0, 0);
    chk("pre_rst_l1", l1c, 1);
    tb_l1 = 1;
    r1_v = 1; r1_a = 11'h345;
    #1;
    chk("mid_grant", r1_rdy, 1);
    step();
    r1_v = 0;
    chk("mid_issue", cread, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_cnt", {l1c, l2c, mc}, 0);
    chk("mid_addr", caddr, 0);
    for (int i = 0; i < 5; i++) begin
      chk("mid_no_rv", r1_rv | r0_rv, 0);
      chk("mid_no_rd", cread, 0);
      step();
    end
    r0_v = 1; r0_a = 11'h055;
    r1_v = 1; r1_a = 11'h066;
    #1;
    chk("post_rst_r0", r0_rdy, 1);
    chk("post_rst_r1", r1_rdy, 0);
    r1_v = 0;
    do_txn(0, 11'h055, 0, 1, 0);
    chk("post_rst_l2", l2c, 1);

    // r1 raised then withdrawn during r0 transaction
    r0_v = 1; r0_a = 11'h077;
    #1;
    chk("wd_grant0", r0_rdy, 1);
    step();
    r0_v = 0;
    r1_v = 1; r1_a = 11'h2A3;
    #1;
    chk("wd_busy", r1_rdy, 0);
    step();
    chk("wd_busy2", r1_rdy, 0);
    step();
    r1_v = 0;
    chk("wd_rv0", r0_rv, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wd_no_rdy", r1_rdy, 0);
      chk("wd_no_rd", cread, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
